bsg_event_timestamper: RTL and testbench

- Downstream consumer of the free-running cycle counter.
- Samples the counter value on each incoming event and computes the elapsed cycles since the previous accepted event, modulo 2^width_p.
- Buffers {timestamp, delta, tag, first} entries in a small FIFO with a valid/yumi output interface.
- Counts events dropped because the FIFO is full; used for performance tracing and interval measurement.

---
 rtl/bsg_event_timestamper_if.sv | 31 +++
 rtl/bsg_event_timestamper.sv | 97 +++++++++
 tb/tb_bsg_event_timestamper.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bsg_event_timestamper_if.sv
// Event-capture and output-queue signals of bsg_event_timestamper.
// The slave modport is the timestamper's own view; master is the producer/consumer view.
interface bsg_event_timestamper_if #(
    parameter int width_p      = 16,
    parameter int tag_width_p  = 4,
    parameter int drop_width_p = 8
);
    logic [width_p-1:0]      ctr_i;
    logic                    event_v_i;
    logic [tag_width_p-1:0]  event_tag_i;
    logic                    yumi_i;
    logic                    clear_drop_i;
    logic                    v_o;
    logic [width_p-1:0]      ts_o;
    logic [width_p-1:0]      delta_o;
    logic [tag_width_p-1:0]  tag_o;
    logic                    first_o;
    logic [drop_width_p-1:0] drop_count_o;
    logic                    overflow_o;

    // Output handshake: v_o marks a valid head entry; yumi_i may only be raised while
    // v_o=1 and pops that entry at the clock edge. Fields are held until popped.
    modport slave (
        input  ctr_i, event_v_i, event_tag_i, yumi_i, clear_drop_i,
        output v_o, ts_o, delta_o, tag_o, first_o, drop_count_o, overflow_o
    );
    modport master (
        output ctr_i, event_v_i, event_tag_i, yumi_i, clear_drop_i,
        input  v_o, ts_o, delta_o, tag_o, first_o, drop_count_o, overflow_o
    );
endinterface

// File: rtl/bsg_event_timestamper.sv
// Timestamps events against a free-running counter, queues {ts, delta, tag, first}
// in a small FIFO, and keeps a saturating count of events lost to a full FIFO.
module bsg_event_timestamper #(
    parameter int width_p      = 16,
    parameter int tag_width_p  = 4,
    parameter int els_p        = 4,
    parameter int drop_width_p = 8
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bsg_event_timestamper_if.slave ports
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;

    logic [width_p-1:0]      ts_mem    [els_p];
    logic [width_p-1:0]      delta_mem [els_p];
    logic [tag_width_p-1:0]  tag_mem   [els_p];
    logic                    first_mem [els_p];

    logic [ptr_w-1:0]        rptr, wptr;
    logic [cnt_w-1:0]        count;
    logic [width_p-1:0]      last_ts;
    logic                    have_last;
    logic [drop_width_p-1:0] drop_cnt;
    logic                    overflow;

    logic                    valid, pop, accept, push, drop;
    logic [width_p-1:0]      new_delta;
    logic [drop_width_p-1:0] drop_base;

    assign valid     = (count != '0);
    // An illegal yumi on an empty FIFO is masked so it cannot corrupt state.
    assign pop       = ports.yumi_i & valid;
    assign accept    = (count < cnt_w'(els_p)) | pop;
    assign push      = ports.event_v_i & accept;
    assign drop      = ports.event_v_i & ~accept;
    assign new_delta = have_last ? (ports.ctr_i - last_ts) : '0;

    // A clear in the same cycle as a drop takes effect first.
    always_comb begin
        drop_base = drop_cnt;
        if (ports.clear_drop_i) drop_base = '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            last_ts   <= '0;
            have_last <= 1'b0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wptr      <= wptr + ptr_w'(1);
                last_ts   <= ports.ctr_i;
                have_last <= 1'b1;
            end
            if (pop) rptr <= rptr + ptr_w'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
            if (drop) begin
                drop_cnt <= (&drop_base) ? drop_base : drop_base + drop_width_p'(1);
                overflow <= 1'b1;
            end else if (ports.clear_drop_i) begin
                drop_cnt <= '0;
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ts_mem[wptr]    <= ports.ctr_i;
            delta_mem[wptr] <= new_delta;
            tag_mem[wptr]   <= ports.event_tag_i;
            first_mem[wptr] <= ~have_last;
        end
    end

    assign ports.v_o          = valid;
    assign ports.ts_o         = ts_mem[rptr];
    assign ports.delta_o      = delta_mem[rptr];
    assign ports.tag_o        = tag_mem[rptr];
    assign ports.first_o      = first_mem[rptr];
    assign ports.drop_count_o = drop_cnt;
    assign ports.overflow_o   = overflow;

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !(ports.yumi_i && !valid));
endmodule

// File: tb/tb_bsg_event_timestamper.sv
// Directed and randomized checks of bsg_event_timestamper against a reference
// model with an expected-entry queue.
module tb_bsg_event_timestamper;
    localparam int W  = 16;
    localparam int TW = 4;
    localparam int EL = 4;
    localparam int DW = 2;
    localparam int EW = W + W + TW + 1;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    bsg_event_timestamper_if #(.width_p(W), .tag_width_p(TW), .drop_width_p(DW)) ports ();

    bsg_event_timestamper #(.width_p(W), .tag_width_p(TW), .els_p(EL), .drop_width_p(DW)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .ports   (ports)
    );

    logic [EW-1:0]  exp_q[$];
    logic [W-1:0]   m_last_ts;
    logic           m_have_last;
    logic [DW-1:0]  m_drops;
    logic           m_ovf;
    logic [W-1:0]   m_ctr;
    int             n_checks;
    int             n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last_ts   = '0;
        m_have_last = 1'b0;
        m_drops     = '0;
        m_ovf       = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".v"}, 64'(ports.v_o), 64'(exp_q.size() != 0));
        check({tag, ".drops"}, 64'(ports.drop_count_o), 64'(m_drops));
        check({tag, ".ovf"}, 64'(ports.overflow_o), 64'(m_ovf));
        if (exp_q.size() != 0)
            check({tag, ".head"}, 64'({ports.ts_o, ports.delta_o, ports.tag_o, ports.first_o}),
                  64'(exp_q[0]));
    endtask

    // One clock: drive inputs, update the model, clock, then check.
    task automatic cycle(input string tag, input logic ev, input logic [W-1:0] ctr,
                         input logic [TW-1:0] etag, input logic yumi, input logic clr);
        logic          pop, acc;
        logic [W-1:0]  d;
        logic [DW-1:0] base;
        pop = yumi && (exp_q.size() != 0);
        ports.event_v_i    = ev;
        ports.ctr_i        = ctr;
        ports.event_tag_i  = etag;
        ports.yumi_i       = pop;
        ports.clear_drop_i = clr;
        acc = (exp_q.size() < EL) || pop;
        if (pop) void'(exp_q.pop_front());
        if (ev && acc) begin
            d = m_have_last ? ctr - m_last_ts : '0;
            exp_q.push_back({ctr, d, etag, ~m_have_last});
            m_last_ts   = ctr;
            m_have_last = 1'b1;
        end
        base = clr ? '0 : m_drops;
        if (ev && !acc) begin
            m_drops = (&base) ? base : base + 1'b1;
            m_ovf   = 1'b1;
        end else if (clr) begin
            m_drops = '0;
            m_ovf   = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, m_ctr, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++)
            cycle(tag, 1'b0, m_ctr, '0, 1'b1, 1'b0);
        check({tag, ".empty"}, 64'(ports.v_o), 64'(0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ctr    = '0;
        model_reset();
        ports.event_v_i = 1'b0; ports.ctr_i = '0; ports.event_tag_i = '0;
        ports.yumi_i = 1'b0; ports.clear_drop_i = 1'b0;
        #2;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        check_outputs("post_reset");

        // Basic capture: first entry visible one cycle later with delta 0 and first=1
        cycle("cap1", 1'b1, 16'h0010, 4'd3, 1'b0, 1'b0);
        check("cap1.ts", 64'(ports.ts_o), 64'h0010);
        check("cap1.first", 64'(ports.first_o), 64'd1);
        cycle("cap2", 1'b1, 16'h0025, 4'd5, 1'b1, 1'b0);
        check("cap2.delta", 64'(ports.delta_o), 64'h0015);
        drain("cap_drain");

        // Counter wrap-around
        cycle("wrap1", 1'b1, 16'hFFFE, 4'd1, 1'b0, 1'b0);
        cycle("wrap2", 1'b1, 16'h0003, 4'd2, 1'b1, 1'b0);
        check("wrap.delta", 64'(ports.delta_o), 64'h0005);
        drain("wrap_drain");

        // Six events into a depth-4 FIFO: two drops
        for (int i = 0; i < 6; i++)
            cycle("fill", 1'b1, 16'h0100 + 16'(i * 7), 4'(i), 1'b0, 1'b0);
        check("fill.drops", 64'(ports.drop_count_o), 64'd2);
        check("fill.ovf", 64'(ports.overflow_o), 64'd1);
        // Full with same-cycle yumi: accepted, no new drop
        cycle("full_yumi", 1'b1, 16'h0200, 4'hA, 1'b1, 1'b0);
        check("full_yumi.drops", 64'(ports.drop_count_o), 64'd2);
        drain("fill_drain");

        // Saturation at 3, clear alone, then clear with a drop
        for (int i = 0; i < 4; i++)
            cycle("refill", 1'b1, 16'h0300 + 16'(i), 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle("sat", 1'b1, 16'h0400 + 16'(i), 4'hF, 1'b0, 1'b0);
        check("sat.drops", 64'(ports.drop_count_o), 64'd3);
        cycle("clr", 1'b0, 16'h0500, '0, 1'b0, 1'b1);
        check("clr.drops", 64'(ports.drop_count_o), 64'd0);
        check("clr.ovf", 64'(ports.overflow_o), 64'd0);
        cycle("clr_drop", 1'b1, 16'h0501, 4'h7, 1'b0, 1'b1);
        check("clr_drop.drops", 64'(ports.drop_count_o), 64'd1);
        check("clr_drop.ovf", 64'(ports.overflow_o), 64'd1);
        drain("sat_drain");

        // Asynchronous reset between clock edges discards queued entries
        for (int i = 0; i < 3; i++)
            cycle("pre_rst", 1'b1, 16'h0600 + 16'(i * 3), 4'(i), 1'b0, 1'b0);
        ports.event_v_i = 1'b0;
        #3 reset_i = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_rst");
        #1 reset_i = 1'b0;
        cycle("after_rst", 1'b1, 16'h0700, 4'h9, 1'b0, 1'b0);
        check("after_rst.first", 64'(ports.first_o), 64'd1);
        check("after_rst.delta", 64'(ports.delta_o), 64'd0);
        drain("rst_drain");

        // Randomized mix of events, pops and clears
        m_ctr = 16'hF000;
        for (int i = 0; i < 60; i++) begin
            m_ctr = m_ctr + 16'($urandom_range(1, 900));
            cycle("rand", 1'($urandom_range(0, 1)), m_ctr, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
